// File: rtl/countersel_key_ctrl.sv
// Two-button front end for countersel: synchronizes and debounces key_next/key_prev
// and steps a 2-bit select code forward/backward, with a one-cycle update strobe.
module countersel_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next,
    input  logic       key_prev,
    output logic [1:0] D_out,
    output logic       D_update,
    output logic       key_busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Index 0 is key_next, index 1 is key_prev throughout.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       warm;
    logic [1:0]       blocked;
    logic [1:0]       press;
    logic [1:0]       pend;
    logic [1:0]       req;
    key_state_t       st  [2];
    logic [CNT_W-1:0] cnt [2];

    assign raw = {key_prev, key_next};

    always_comb begin
        press = 2'b00;
        for (int k = 0; k < 2; k++) begin
            press[k] = (st[k] == PRESS_WAIT) && (cnt[k] == CNT_MAX) && sync2[k];
        end
        req = pend | press;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            warm     <= 2'b00;
            blocked  <= 2'b11;
            pend     <= 2'b00;
            D_out    <= 2'b00;
            D_update <= 1'b0;
            key_busy <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                st[k]  <= IDLE;
                cnt[k] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};

            // A key held through reset stays locked out until the synchronized
            // level (valid once warm[1] is set) shows it released.
            for (int k = 0; k < 2; k++) begin
                if (blocked[k]) begin
                    st[k]  <= IDLE;
                    cnt[k] <= '0;
                    if (warm[1] && !sync2[k]) begin
                        blocked[k] <= 1'b0;
                    end
                end else begin
                    case (st[k])
                        IDLE: begin
                            if (sync2[k]) begin
                                st[k]  <= PRESS_WAIT;
                                cnt[k] <= '0;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!sync2[k]) begin
                                st[k]  <= IDLE;
                                cnt[k] <= '0;
                            end else if (cnt[k] == CNT_MAX) begin
                                st[k] <= HELD;
                            end else begin
                                cnt[k] <= cnt[k] + CNT_ONE;
                            end
                        end
                        HELD: begin
                            if (!sync2[k]) begin
                                st[k]  <= RELEASE_WAIT;
                                cnt[k] <= '0;
                            end
                        end
                        RELEASE_WAIT: begin
                            if (sync2[k]) begin
                                st[k] <= HELD;
                            end else if (cnt[k] == CNT_MAX) begin
                                st[k] <= IDLE;
                            end else begin
                                cnt[k] <= cnt[k] + CNT_ONE;
                            end
                        end
                        default: begin
                            st[k]  <= IDLE;
                            cnt[k] <= '0;
                        end
                    endcase
                end
            end

            // A press arriving right after an update is parked for one cycle so
            // the strobe never stays high on back-to-back cycles.
            if (D_update) begin
                pend     <= req;
                D_update <= 1'b0;
            end else begin
                pend <= 2'b00;
                if (req == 2'b01) begin
                    D_out    <= D_out + 2'd1;
                    D_update <= 1'b1;
                end else if (req == 2'b10) begin
                    D_out    <= D_out - 2'd1;
                    D_update <= 1'b1;
                end else begin
                    D_update <= 1'b0;
                end
            end

            key_busy <= (st[0] == HELD) || (st[0] == RELEASE_WAIT) ||
                        (st[1] == HELD) || (st[1] == RELEASE_WAIT);
        end
    end

endmodule

// File: tb/tb_countersel_key_ctrl.sv
// Directed bench for countersel_key_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_countersel_key_ctrl;

    logic       clk;
    logic       rst;
    logic       key_next;
    logic       key_prev;
    logic [1:0] D_out;
    logic       D_update;
    logic       key_busy;

    int n_checks;
    int n_fail;
    int upd_cnt;
    int consec;
    logic last_upd;

    countersel_key_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_next(key_next),
        .key_prev(key_prev),
        .D_out   (D_out),
        .D_update(D_update),
        .key_busy(key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks, sampling 1 ns after each rising edge and tallying strobes.
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (D_update) begin
                upd_cnt++;
                if (last_upd) consec++;
            end
            last_upd = D_update;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(4);
        upd_cnt  = 0;
        consec   = 0;
        last_upd = 1'b0;
    endtask

    task automatic press_next(input int hi, input int lo);
        key_next = 1'b1;
        hold(hi);
        key_next = 1'b0;
        hold(lo);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_next = 1'b0;
        key_prev = 1'b0;
        upd_cnt = 0;
        consec = 0;
        last_upd = 1'b0;
        hold(3);
        n_checks++;
        if (D_out !== 2'b00) begin n_fail++; $display("FAIL reset_d_out: got %b expected 00", D_out); end
        n_checks++;
        if (D_update !== 1'b0) begin n_fail++; $display("FAIL reset_d_update: got %b expected 0", D_update); end
        n_checks++;
        if (key_busy !== 1'b0) begin n_fail++; $display("FAIL reset_key_busy: got %b expected 0", key_busy); end
        rst = 1'b0;
        hold(4);
    endtask

    task automatic test_clean_presses();
        logic [1:0] exp_code;
        int seen;
        int at;
        exp_code = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_code = exp_code + 2'd1;
            seen = 0;
            at = -1;
            key_next = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                if (c == 11) key_next = 1'b0;
                @(posedge clk);
                #1;
                if (D_update) begin
                    seen++;
                    at = c;
                end
            end
            n_checks++;
            if (D_out !== exp_code) begin n_fail++; $display("FAIL clean_code[%0d]: got %b expected %b", i, D_out, exp_code); end
            n_checks++;
            if (seen != 1) begin n_fail++; $display("FAIL clean_pulses[%0d]: got %0d expected 1", i, seen); end
            n_checks++;
            if (at != 7) begin n_fail++; $display("FAIL clean_latency[%0d]: got %0d expected 7", i, at); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press_next(10, 10);
        press_next(10, 10);
        n_checks++;
        if (D_out !== 2'b10) begin n_fail++; $display("FAIL async_pre_code: got %b expected 10", D_out); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (D_out !== 2'b00) begin n_fail++; $display("FAIL async_d_out: got %b expected 00", D_out); end
        n_checks++;
        if (D_update !== 1'b0) begin n_fail++; $display("FAIL async_d_update: got %b expected 0", D_update); end
        n_checks++;
        if (key_busy !== 1'b0) begin n_fail++; $display("FAIL async_key_busy: got %b expected 0", key_busy); end
        hold(2);
        rst = 1'b0;
        hold(4);
    endtask

    task automatic test_prev_wrap();
        do_reset();
        key_prev = 1'b1;
        hold(10);
        key_prev = 1'b0;
        hold(10);
        n_checks++;
        if (D_out !== 2'b11) begin n_fail++; $display("FAIL prev_wrap_code: got %b expected 11", D_out); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL prev_wrap_pulses: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_bounce();
        do_reset();
        key_next = 1'b1; hold(1);
        key_next = 1'b0; hold(2);
        key_next = 1'b1; hold(2);
        key_next = 1'b0; hold(1);
        key_next = 1'b1; hold(8);
        key_next = 1'b0; hold(1);
        key_next = 1'b1; hold(1);
        key_next = 1'b0; hold(12);
        n_checks++;
        if (D_out !== 2'b01) begin n_fail++; $display("FAIL bounce_code: got %b expected 01", D_out); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        key_next = 1'b1;
        key_prev = 1'b1;
        hold(8);
        n_checks++;
        if (key_busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_held: got %b expected 1", key_busy); end
        key_next = 1'b0;
        key_prev = 1'b0;
        hold(12);
        n_checks++;
        if (D_out !== 2'b00) begin n_fail++; $display("FAIL simul_code: got %b expected 00", D_out); end
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL simul_pulses: got %0d expected 0", upd_cnt); end
        n_checks++;
        if (key_busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy_released: got %b expected 0", key_busy); end
    endtask

    task automatic test_long_hold();
        do_reset();
        press_next(50, 12);
        n_checks++;
        if (D_out !== 2'b01) begin n_fail++; $display("FAIL long_hold_code: got %b expected 01", D_out); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL long_hold_pulses: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        key_next = 1'b1;
        hold(4);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        hold(20);
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL mid_reset_pulses: got %0d expected 0", upd_cnt); end
        n_checks++;
        if (D_out !== 2'b00) begin n_fail++; $display("FAIL mid_reset_code: got %b expected 00", D_out); end
        n_checks++;
        if (key_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", key_busy); end
        key_next = 1'b0;
        hold(5);
        press_next(10, 12);
        n_checks++;
        if (D_out !== 2'b01) begin n_fail++; $display("FAIL repress_code: got %b expected 01", D_out); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL repress_pulses: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_back_to_back();
        // next and prev accepted on adjacent cycles: +1 then -1, strobes separated.
        do_reset();
        key_next = 1'b1;
        hold(1);
        key_prev = 1'b1;
        hold(10);
        key_next = 1'b0;
        key_prev = 1'b0;
        hold(12);
        n_checks++;
        if (upd_cnt != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", upd_cnt); end
        n_checks++;
        if (consec != 0) begin n_fail++; $display("FAIL b2b_consecutive: got %0d expected 0", consec); end
        n_checks++;
        if (D_out !== 2'b00) begin n_fail++; $display("FAIL b2b_code: got %b expected 00", D_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_presses();
        test_async_reset();
        test_prev_wrap();
        test_bounce();
        test_simultaneous();
        test_long_hold();
        test_reset_mid_press();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
